// File: rtl/mem_access_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_pkg
// Shared types and constants for the mem_access load/store unit:
//   funct3_e   RISC-V load/store size/sign codes (B, H, W, BU, HU)
//   state_e    access FSM states
//   BE_*       byte-enable patterns for store formatting
//   op_is_err  legality/alignment check for an incoming operation
// -----------------------------------------------------------------------------
package mem_access_pkg;

   localparam int CNT_WIDTH = 32;

   typedef enum logic [2:0] {
      F3_B  = 3'b000,
      F3_H  = 3'b001,
      F3_W  = 3'b010,
      F3_BU = 3'b100,
      F3_HU = 3'b101
   } funct3_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_RESP    = 2'd3
   } state_e;

   localparam logic [3:0] BE_NONE    = 4'b0000;
   localparam logic [3:0] BE_BYTE    = 4'b0001;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_WORD    = 4'b1111;

   // Returns 1 when the operation is misaligned or uses an illegal funct3.
   // BU/HU are unsigned load forms only, so a store using them is illegal.
   function automatic logic op_is_err(input logic [2:0] f3,
                                      input logic       store,
                                      input logic [1:0] addr_lo);
      logic err;
      err = 1'b1;
      case (f3)
         F3_B:    err = 1'b0;
         F3_H:    err = addr_lo[0];
         F3_W:    err = (addr_lo != 2'b00);
         F3_BU:   err = store;
         F3_HU:   err = store | addr_lo[0];
         default: err = 1'b1;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/mem_access_if.sv
// -----------------------------------------------------------------------------
// mem_access_if
// Bundles the pipeline-side operation/response handshake, the downstream cache
// port and the performance counters of mem_access.
//   slave  : view of mem_access (takes ops, drives responses and cache port)
//   master : view of the surrounding pipeline + cache (drives ops, cache data)
// -----------------------------------------------------------------------------
interface mem_access_if;
   import mem_access_pkg::*;

   // pipeline operation
   logic                 op_valid;
   logic                 op_ready;
   logic                 op_store;
   logic [2:0]           op_funct3;
   logic [31:0]          op_addr;
   logic [31:0]          op_wdata;
   // pipeline response
   logic                 resp_valid;
   logic [31:0]          resp_rdata;
   logic                 resp_err;
   // downstream cache
   logic [31:0]          cache_addr;
   logic                 cache_rd_req;
   logic                 cache_wr_req;
   logic [3:0]           cache_write_en;
   logic [31:0]          cache_wr_data;
   logic [31:0]          cache_rd_data;
   logic                 cache_miss;
   // performance counters
   logic [CNT_WIDTH-1:0] access_cnt;
   logic [CNT_WIDTH-1:0] miss_cnt;

   modport slave (
      input  op_valid, op_store, op_funct3, op_addr, op_wdata,
      input  cache_rd_data, cache_miss,
      output op_ready, resp_valid, resp_rdata, resp_err,
      output cache_addr, cache_rd_req, cache_wr_req, cache_write_en, cache_wr_data,
      output access_cnt, miss_cnt
   );

   modport master (
      output op_valid, op_store, op_funct3, op_addr, op_wdata,
      output cache_rd_data, cache_miss,
      input  op_ready, resp_valid, resp_rdata, resp_err,
      input  cache_addr, cache_rd_req, cache_wr_req, cache_write_en, cache_wr_data,
      input  access_cnt, miss_cnt
   );

endinterface

// File: rtl/mem_access_load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Combinational load formatter: picks the byte/half/word addressed by
// addr_lo_i out of the cache word and sign- or zero-extends it.
//   funct3_i  : load size/sign code
//   addr_lo_i : address bits [1:0]
//   word_i    : 32-bit word returned by the cache
//   data_o    : right-aligned, extended load data
// -----------------------------------------------------------------------------
module load_align
   import mem_access_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] word_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Lane selection from the low address bits.
   always_comb begin
      byte_s = 8'h00;
      case (addr_lo_i)
         2'd0:    byte_s = word_i[7:0];
         2'd1:    byte_s = word_i[15:8];
         2'd2:    byte_s = word_i[23:16];
         2'd3:    byte_s = word_i[31:24];
         default: byte_s = 8'h00;
      endcase
      if (addr_lo_i[1]) begin
         half_s = word_i[31:16];
      end else begin
         half_s = word_i[15:0];
      end
   end

   // Extension according to the size/sign code.
   always_comb begin
      data_o = 32'h0000_0000;
      case (funct3_i)
         F3_B:    data_o = {{24{byte_s[7]}}, byte_s};
         F3_BU:   data_o = {24'h00_0000, byte_s};
         F3_H:    data_o = {{16{half_s[15]}}, half_s};
         F3_HU:   data_o = {16'h0000, half_s};
         F3_W:    data_o = word_i;
         default: data_o = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access
// Load/store unit between the pipeline and a blocking downstream cache.
// Accepts one operation at a time in IDLE, checks alignment/legality, holds
// the cache request through any miss cycles, formats load data and returns a
// one-cycle response. Counts legal accesses and accesses that missed.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : mem_access_if.slave (operation, response, cache port, counters)
// -----------------------------------------------------------------------------
module mem_access
   import mem_access_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   mem_access_if.slave bus
);

   state_e               state_q;
   logic                 op_ready_q;
   logic                 store_q;
   logic [2:0]           funct3_q;
   logic                 first_q;      // first ACCESS cycle of the current op
   logic                 resp_valid_q;
   logic [31:0]          resp_rdata_q;
   logic                 resp_err_q;
   logic [31:0]          cache_addr_q; // doubles as the latched op address
   logic                 cache_rd_req_q;
   logic                 cache_wr_req_q;
   logic [3:0]           cache_write_en_q;
   logic [31:0]          cache_wr_data_q;
   logic [CNT_WIDTH-1:0] access_cnt_q;
   logic [CNT_WIDTH-1:0] miss_cnt_q;

   logic                 accept_s;
   logic                 op_err_s;
   logic [3:0]           store_be_s;
   logic [31:0]          store_data_s;
   logic [31:0]          load_data_s;

   assign accept_s = bus.op_valid & op_ready_q;
   assign op_err_s = op_is_err(bus.op_funct3, bus.op_store, bus.op_addr[1:0]);

   // Store lane replication and byte enables for the incoming operation.
   always_comb begin
      store_be_s   = BE_NONE;
      store_data_s = 32'h0000_0000;
      case (bus.op_funct3)
         F3_B: begin
            store_be_s   = 4'(BE_BYTE << bus.op_addr[1:0]);
            store_data_s = {4{bus.op_wdata[7:0]}};
         end
         F3_H: begin
            if (bus.op_addr[1]) begin
               store_be_s = BE_HALF_HI;
            end else begin
               store_be_s = BE_HALF_LO;
            end
            store_data_s = {2{bus.op_wdata[15:0]}};
         end
         F3_W: begin
            store_be_s   = BE_WORD;
            store_data_s = bus.op_wdata;
         end
         default: begin
            store_be_s   = BE_NONE;
            store_data_s = 32'h0000_0000;
         end
      endcase
   end

   // Load data arrives from the cache one edge after the hit, so it is
   // formatted from the latched funct3/address during CAPTURE.
   load_align u_load_align (
      .funct3_i  (funct3_q),
      .addr_lo_i (cache_addr_q[1:0]),
      .word_i    (bus.cache_rd_data),
      .data_o    (load_data_s)
   );

   // Access FSM with all outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= ST_IDLE;
         op_ready_q       <= 1'b1;
         store_q          <= 1'b0;
         funct3_q         <= 3'b000;
         first_q          <= 1'b0;
         resp_valid_q     <= 1'b0;
         resp_rdata_q     <= 32'h0000_0000;
         resp_err_q       <= 1'b0;
         cache_addr_q     <= 32'h0000_0000;
         cache_rd_req_q   <= 1'b0;
         cache_wr_req_q   <= 1'b0;
         cache_write_en_q <= 4'b0000;
         cache_wr_data_q  <= 32'h0000_0000;
         access_cnt_q     <= '0;
         miss_cnt_q       <= '0;
      end else begin
         // Response flags are single-cycle pulses.
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept_s) begin
                  store_q      <= bus.op_store;
                  funct3_q     <= bus.op_funct3;
                  cache_addr_q <= bus.op_addr;
                  op_ready_q   <= 1'b0;
                  if (op_err_s) begin
                     // Error ops never reach the cache.
                     state_q      <= ST_RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     if (!bus.op_store) begin
                        resp_rdata_q <= 32'h0000_0000;
                     end
                  end else begin
                     state_q        <= ST_ACCESS;
                     first_q        <= 1'b1;
                     cache_rd_req_q <= ~bus.op_store;
                     cache_wr_req_q <= bus.op_store;
                     access_cnt_q   <= access_cnt_q + CNT_WIDTH'(1);
                     if (bus.op_store) begin
                        cache_write_en_q <= store_be_s;
                        cache_wr_data_q  <= store_data_s;
                     end else begin
                        cache_write_en_q <= 4'b0000;
                        cache_wr_data_q  <= 32'h0000_0000;
                     end
                  end
               end
            end
            ST_ACCESS: begin
               first_q <= 1'b0;
               // A miss is counted once per op, only on its first cycle.
               if (first_q && bus.cache_miss) begin
                  miss_cnt_q <= miss_cnt_q + CNT_WIDTH'(1);
               end
               if (!bus.cache_miss) begin
                  cache_rd_req_q   <= 1'b0;
                  cache_wr_req_q   <= 1'b0;
                  cache_write_en_q <= 4'b0000;
                  cache_wr_data_q  <= 32'h0000_0000;
                  if (store_q) begin
                     state_q      <= ST_RESP;
                     resp_valid_q <= 1'b1;
                  end else begin
                     state_q <= ST_CAPTURE;
                  end
               end
            end
            ST_CAPTURE: begin
               resp_rdata_q <= load_data_s;
               resp_valid_q <= 1'b1;
               state_q      <= ST_RESP;
            end
            ST_RESP: begin
               state_q    <= ST_IDLE;
               op_ready_q <= 1'b1;
            end
            default: begin
               state_q          <= ST_IDLE;
               op_ready_q       <= 1'b1;
               cache_rd_req_q   <= 1'b0;
               cache_wr_req_q   <= 1'b0;
               cache_write_en_q <= 4'b0000;
               cache_wr_data_q  <= 32'h0000_0000;
            end
         endcase
      end
   end

   assign bus.op_ready       = op_ready_q;
   assign bus.resp_valid     = resp_valid_q;
   assign bus.resp_rdata     = resp_rdata_q;
   assign bus.resp_err       = resp_err_q;
   assign bus.cache_addr     = cache_addr_q;
   assign bus.cache_rd_req   = cache_rd_req_q;
   assign bus.cache_wr_req   = cache_wr_req_q;
   assign bus.cache_write_en = cache_write_en_q;
   assign bus.cache_wr_data  = cache_wr_data_q;
   assign bus.access_cnt     = access_cnt_q;
   assign bus.miss_cnt       = miss_cnt_q;

endmodule

// File: tb/tb_mem_access.sv
// -----------------------------------------------------------------------------
// tb_mem_access
// Directed bench for mem_access: a table of load/store vectors with
// hand-computed results, plus sequences for long misses and reset mid-miss.
// A small cache model returns rd_data one edge after a load hit and records
// store writes.
// -----------------------------------------------------------------------------
module tb_mem_access;
   import mem_access_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   mem_access_if bus ();

   mem_access dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        st;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] word;
      logic        err;
      logic [31:0] rdata;
      logic [3:0]  we;
      logic [31:0] wd;
   } vec_t;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          exp_acc = 0;
   int          exp_miss = 0;
   logic [31:0] exp_hold = 32'h0;
   logic [31:0] cache_word = 32'h0;

   // cache model / monitor state (written only by the always block below)
   int          req_cnt = 0;
   int          wr_cnt = 0;
   logic [3:0]  last_we = 4'h0;
   logic [31:0] last_wd = 32'h0;

   // Cache model: read data registered on the hit edge; stores recorded.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.cache_rd_data <= 32'h0;
      end else begin
         if (bus.cache_rd_req && !bus.cache_miss) bus.cache_rd_data <= cache_word;
         if (bus.cache_rd_req || bus.cache_wr_req) req_cnt <= req_cnt + 1;
         if (bus.cache_wr_req && !bus.cache_miss) begin
            last_we <= bus.cache_write_en;
            last_wd <= bus.cache_wr_data;
            wr_cnt  <= wr_cnt + 1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] word,
                               input logic err, input logic [31:0] rdata,
                               input logic [3:0] we, input logic [31:0] wd);
      vec_t v;
      v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.word = word;
      v.err = err; v.rdata = rdata; v.we = we; v.wd = wd;
      return v;
   endfunction

   // Issue one op, hold cache_miss for nmiss edges, check the response.
   task automatic run_op(input vec_t v, input int nmiss, input bit no_wait);
      int lat;
      int exp_lat;
      bit seen;
      bit hold_ok;
      bit rdy_ok;
      int req0;
      int wr0;
      if (!no_wait) @(negedge clk);
      cache_word     = v.word;
      req0           = req_cnt;
      wr0            = wr_cnt;
      bus.op_valid   = 1'b1;
      bus.op_store   = v.st;
      bus.op_funct3  = v.f3;
      bus.op_addr    = v.addr;
      bus.op_wdata   = v.wdata;
      bus.cache_miss = (nmiss > 0);
      @(posedge clk);
      seen = 1'b0; lat = 0; hold_ok = 1'b1; rdy_ok = 1'b1;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         bus.op_valid = 1'b0;
         if (bus.op_ready !== 1'b0) rdy_ok = 1'b0;
         if (bus.resp_valid === 1'b1) begin
            seen = 1'b1;
            lat  = c;
            break;
         end
         if (!v.err && c <= nmiss + 1) begin
            if (v.st) begin
               if (bus.cache_wr_req !== 1'b1) hold_ok = 1'b0;
            end else begin
               if (bus.cache_rd_req !== 1'b1) hold_ok = 1'b0;
            end
         end
         bus.cache_miss = (c <= nmiss);
      end
      bus.cache_miss = 1'b0;
      if (v.err) exp_lat = 1;
      else if (v.st) exp_lat = 2 + nmiss;
      else exp_lat = 3 + nmiss;
      if (!v.err) begin
         exp_acc++;
         if (nmiss > 0) exp_miss++;
      end
      if (!v.st) exp_hold = v.rdata;
      check("resp_seen", 32'(seen), 32'd1);
      check("latency", 32'(lat), 32'(exp_lat));
      check("resp_err", 32'(bus.resp_err), 32'(v.err));
      check("resp_rdata", bus.resp_rdata, exp_hold);
      check("op_ready_low", 32'(rdy_ok), 32'd1);
      if (v.err) begin
         check("no_cache_req", 32'(req_cnt - req0), 32'd0);
      end else begin
         check("req_held", 32'(hold_ok), 32'd1);
      end
      if (v.st && !v.err) begin
         check("write_cnt", 32'(wr_cnt - wr0), 32'd1);
         check("write_en", 32'(last_we), 32'(v.we));
         check("wr_data", last_wd, v.wd);
      end
   endtask

   vec_t tbl[14];

   initial begin
      bus.op_valid  = 1'b0;
      bus.op_store  = 1'b0;
      bus.op_funct3 = 3'b000;
      bus.op_addr   = 32'h0;
      bus.op_wdata  = 32'h0;
      bus.cache_miss = 1'b0;

      //        st    f3      addr          wdata         word          err   rdata         we       wd
      tbl[0]  = mk(1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 4'h0,    32'h0);
      tbl[1]  = mk(1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h8012_3456, 1'b0, 32'hFFFF_FF80, 4'h0,    32'h0);
      tbl[2]  = mk(1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h8012_3456, 1'b0, 32'h0000_0080, 4'h0,    32'h0);
      tbl[3]  = mk(1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'h8012_3456, 1'b0, 32'h0000_8012, 4'h0,    32'h0);
      tbl[4]  = mk(1'b0, 3'b001, 32'h0000_0100, 32'h0,        32'h1234_F00D, 1'b0, 32'hFFFF_F00D, 4'h0,    32'h0);
      tbl[5]  = mk(1'b0, 3'b000, 32'h0000_0100, 32'h0,        32'h8012_3456, 1'b0, 32'h0000_0056, 4'h0,    32'h0);
      tbl[6]  = mk(1'b1, 3'b000, 32'h0000_0101, 32'h0000_00AB, 32'h0,       1'b0, 32'h0,         4'b0010, 32'hABAB_ABAB);
      tbl[7]  = mk(1'b1, 3'b001, 32'h0000_0102, 32'h0000_BEEF, 32'h0,       1'b0, 32'h0,         4'b1100, 32'hBEEF_BEEF);
      tbl[8]  = mk(1'b1, 3'b010, 32'h0000_0104, 32'h1234_5678, 32'h0,       1'b0, 32'h0,         4'b1111, 32'h1234_5678);
      tbl[9]  = mk(1'b0, 3'b001, 32'h0000_0101, 32'h0,        32'h0,        1'b1, 32'h0,         4'h0,    32'h0);
      tbl[10] = mk(1'b1, 3'b010, 32'h0000_0102, 32'h5555_5555, 32'h0,       1'b1, 32'h0,         4'h0,    32'h0);
      tbl[11] = mk(1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,        1'b1, 32'h0,         4'h0,    32'h0);
      tbl[12] = mk(1'b1, 3'b100, 32'h0000_0100, 32'h0000_0011, 32'h0,       1'b1, 32'h0,         4'h0,    32'h0);
      tbl[13] = mk(1'b0, 3'b101, 32'h0000_0101, 32'h0,        32'h0,        1'b1, 32'h0,         4'h0,    32'h0);

      // reset state
      repeat (3) @(negedge clk);
      check("rst_op_ready", 32'(bus.op_ready), 32'd1);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst_access_cnt", bus.access_cnt, 32'd0);
      rst = 1'b0;

      // table-driven vectors, all hits
      for (int i = 0; i < 14; i++) begin
         run_op(tbl[i], 0, 1'b0);
         if (i == 0) begin
            check("lw_access_cnt", bus.access_cnt, 32'd1);
            check("lw_miss_cnt", bus.miss_cnt, 32'd0);
         end
      end
      // errors leave the access count untouched
      check("table_access_cnt", bus.access_cnt, 32'(exp_acc));
      check("table_miss_cnt", bus.miss_cnt, 32'(exp_miss));

      // long miss on a load: 20 miss edges
      run_op(mk(1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 4'h0, 32'h0), 20, 1'b0);
      check("miss_cnt_after_lw", bus.miss_cnt, 32'(exp_miss));
      @(negedge clk);
      check("resp_pulse_drop", 32'(bus.resp_valid), 32'd0);
      check("ready_after_resp", 32'(bus.op_ready), 32'd1);

      // store with 3 misses; load data must be held
      run_op(mk(1'b1, 3'b001, 32'h0000_0300, 32'h0000_1234, 32'h0, 1'b0, 32'h0, 4'b0011, 32'h1234_1234), 3, 1'b0);
      check("acc_cnt_after_miss", bus.access_cnt, 32'(exp_acc));
      check("miss_cnt_after_sh", bus.miss_cnt, 32'(exp_miss));

      // reset asserted while a load waits on a miss
      @(negedge clk);
      cache_word     = 32'h0;
      bus.op_valid   = 1'b1;
      bus.op_store   = 1'b0;
      bus.op_funct3  = 3'b010;
      bus.op_addr    = 32'h0000_0400;
      bus.cache_miss = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.op_valid = 1'b0;
      check("pre_rst_rd_req", 32'(bus.cache_rd_req), 32'd1);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      check("arst_rd_req", 32'(bus.cache_rd_req), 32'd0);
      check("arst_cache_addr", bus.cache_addr, 32'd0);
      check("arst_write_en", 32'(bus.cache_write_en), 32'd0);
      check("arst_resp_rdata", bus.resp_rdata, 32'd0);
      check("arst_resp_err", 32'(bus.resp_err), 32'd0);
      check("arst_access_cnt", bus.access_cnt, 32'd0);
      check("arst_miss_cnt", bus.miss_cnt, 32'd0);
      check("arst_op_ready", 32'(bus.op_ready), 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      bus.cache_miss = 1'b0;
      exp_acc  = 0;
      exp_miss = 0;
      exp_hold = 32'h0;
      // accepted on the first edge after release
      run_op(mk(1'b0, 3'b010, 32'h0000_0500, 32'h0, 32'h0BAD_CAFE, 1'b0, 32'h0BAD_CAFE, 4'h0, 32'h0), 0, 1'b1);
      check("post_rst_access_cnt", bus.access_cnt, 32'd1);
      check("post_rst_miss_cnt", bus.miss_cnt, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
